operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage directly downstream of the 64-bit, 32-entry register file. It accepts decoded instructions over valid/ready, drives the register file read addresses, and collects the read data one cycle later. It forwards same-cycle and in-flight write-port traffic so that operands are never stale, then holds the instruction and operands until the execute stage accepts them.

## Interface
- XLEN, 64, operand and PC width; equals the register file data width.
- CTRL_W, 32, width of the opaque decoded-control bundle carried alongside the instruction.

- clk  in  1  sole clock; the register file uses the same clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill; empties the stage.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  XLEN  instruction PC.
- in_ctrl  in  CTRL_W  decoded control bundle.
- in_rs1 / in_rs2  in  5  source register indices.
- in_rd  in  5  destination index; passthrough only.
- rf_r_reg1 / rf_r_reg2  out  5  register file read addresses.
- rf_r_data1 / rf_r_data2  in  XLEN  register file read data, valid one cycle after the address.
- wb_en / wb_reg / wb_data  in  1 / 5 / XLEN  snoop of the register file write port.
- out_valid  out  1  instruction and operands valid.
- out_ready  in  1  execute stage accepts.
- out_pc / out_ctrl / out_rd  out  XLEN / CTRL_W / 5  registered passthrough.
- out_op1 / out_op2  out  XLEN  resolved operands.

## Operation
- accept = in_valid && in_ready. fire = out_valid && out_ready.
- in_ready = !rst && !flush && (state==EMPTY || out_ready).
- rf_r_reg1/2 = in_rs1/in_rs2, combinational. The register file samples them at every edge, and its data is meaningful only in the cycle after an accept.
- States:
  - EMPTY: nothing held.
  - FRESH: operands come from rf_r_data.
  - HELD: operands come from local op registers.
- Transitions, with rst or flush taking priority and forcing EMPTY:
  - EMPTY: accept goes to FRESH; otherwise stay in EMPTY.
  - FRESH: accept goes to FRESH (fire is implied). fire without accept goes to EMPTY. !out_ready goes to HELD, and the resolved operands are latched into the op registers.
  - HELD: accept goes to FRESH. fire without accept goes to EMPTY. Otherwise stay in HELD.
- Accept-edge bypass:
  - The register file returns the pre-write value when a read and a write to the same index share an edge.
  - At the accept edge, if wb_en && wb_reg==in_rsN && in_rsN!=0, capture wb_data into byp_N and set byp_vld_N. Otherwise clear byp_vld_N.
- Operand resolution for N in {1,2}, highest priority first:
  1. rsN==0 gives 0.
  2. A current-cycle write hit (wb_en && wb_reg==rsN) gives wb_data, combinationally.
  3. In FRESH: byp_vld_N ? byp_N : rf_r_dataN.
  4. In HELD: opN register.
- In HELD, every edge with a write hit updates opN with wb_data. In FRESH, a write hit is also folded into the value latched on the FRESH-to-HELD transition.
- Operands therefore always reflect every write committed up to and including the cycle the instruction leaves. RAW stalling on producers that have not yet written back is the job of upstream hazard logic, not this block.
- Writes to index 0 are never forwarded.
- Passthrough fields (pc, ctrl, rd, rs1, rs2) are registered at accept and are stable while out_valid && !out_ready.

## Timing
- Reset (rst high at an edge): state=EMPTY, out_valid=0, out_pc/out_ctrl/out_rd/out_op1/out_op2=0, byp_vld=0, in_ready=0 while rst is high.
- Latency: accept at edge E gives out_valid=1 in the cycle following E.
- Throughput: one instruction per cycle with out_ready held high.
- out_valid must not drop and its payload must not change while out_ready=0, except for operand updates caused by write hits.
- flush mid-operation: the held instruction is dropped at that edge, and any same-cycle in_valid is not accepted (in_ready=0).
- Simultaneous fire, accept and write hit: the outgoing instruction's operand shows wb_data, and the incoming instruction captures byp.
- The combinational path runs wb_data to out_op only; there is no path from out_ready to out_op.

## Test plan
- Basic: preload x5=0x11, x6=0x22. Send rs1=5, rs2=6, out_ready=1. Required: out_valid one cycle after accept, op1=0x11, op2=0x22.
- Accept-edge bypass: accept rs1=7 while wb_en=1, wb_reg=7, wb_data=0xABCD. Required: op1=0xABCD, not the stale register file value.
- Backpressure: out_ready=0 for 4 cycles with rs2=9, writing x9=0x55 during cycle 2 of the stall. Required: HELD state, payload stable, op2 becomes 0x55, released when out_ready goes to 1.
- x0: rs1=0 with wb_en=1, wb_reg=0, wb_data=0xFFFF. Required: op1=0.
- Back-to-back: 8 instructions with out_ready=1. Required: 8 consecutive out_valid cycles with in-order PCs. Toggling out_ready 1/0 must lose and duplicate no instructions.
- flush and rst while HELD, with in_valid=1 on the same edge. Required: out_valid=0 next cycle, input not accepted, all outputs 0 after rst.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch
// ---------------------------------------------------------------------------
// Operand-fetch stage that sits directly after the 64-bit, 32-entry register
// file. It takes decoded instructions over valid/ready and drives the register
// file read addresses straight from the incoming source indices. It picks up
// the read data one cycle later and holds the instruction until execute takes
// it. While the instruction waits, its operands keep following the register
// file write port, so they are never stale.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   flush                     synchronous pipeline kill, empties the stage
//   in_valid / in_ready       upstream handshake
//   in_pc, in_ctrl, in_rd     passthrough fields, registered at accept
//   in_rs1, in_rs2            source register indices
//   rf_r_reg1/2               register file read addresses (combinational)
//   rf_r_data1/2              register file read data, one cycle after address
//   wb_en, wb_reg, wb_data    snoop of the register file write port
//   out_valid / out_ready     downstream handshake
//   out_pc, out_ctrl, out_rd  registered passthrough
//   out_op1, out_op2          resolved operands
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    output logic [4:0]        rf_r_reg1,
    output logic [4:0]        rf_r_reg2,
    input  logic [XLEN-1:0]   rf_r_data1,
    input  logic [XLEN-1:0]   rf_r_data2,
    input  logic              wb_en,
    input  logic [4:0]        wb_reg,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2
);

    // EMPTY: nothing held. FRESH: operands come from the register file read
    // data (first cycle after accept). HELD: operands come from op1_q/op2_q.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t          state;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [XLEN-1:0] byp1;
    logic [XLEN-1:0] byp2;
    logic            byp_vld1;
    logic            byp_vld2;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic            accept;
    logic            fire;
    logic [XLEN-1:0] res1;
    logic [XLEN-1:0] res2;

    // Order matters: x0 wins, then a write landing this cycle, then whatever
    // source the current state is using.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      rs,
        input logic            fresh,
        input logic            bv,
        input logic [XLEN-1:0] byp,
        input logic [XLEN-1:0] rfd,
        input logic [XLEN-1:0] opq
    );
        if (rs == 5'd0)
            return '0;
        else if (wb_en && (wb_reg == rs))
            return wb_data;
        else if (fresh)
            return bv ? byp : rfd;
        else
            return opq;
    endfunction

    assign in_ready  = !rst && !flush && ((state == EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign fire      = out_valid && out_ready;

    // The register file samples these addresses at every edge. Its data is
    // only used in the cycle right after an accept.
    assign rf_r_reg1 = in_rs1;
    assign rf_r_reg2 = in_rs2;

    always_comb begin
        res1 = resolve(rs1_q, state == FRESH, byp_vld1, byp1, rf_r_data1, op1_q);
        res2 = resolve(rs2_q, state == FRESH, byp_vld2, byp2, rf_r_data2, op2_q);
    end

    assign out_op1 = res1;
    assign out_op2 = res2;

    // When the stage stays occupied without firing, it latches the resolved
    // operands. This covers FRESH->HELD and HELD->HELD. A write hit in that
    // cycle is already folded into res, so the op registers track every
    // write. The register file returns the pre-write value when a read and a
    // write to the same index share an edge, so a write on the accept edge
    // is captured separately into byp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_pc   <= '0;
            out_ctrl <= '0;
            out_rd   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            byp1     <= '0;
            byp2     <= '0;
            byp_vld1 <= 1'b0;
            byp_vld2 <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state    <= FRESH;
            out_pc   <= in_pc;
            out_ctrl <= in_ctrl;
            out_rd   <= in_rd;
            rs1_q    <= in_rs1;
            rs2_q    <= in_rs2;
            byp_vld1 <= wb_en && (wb_reg == in_rs1) && (in_rs1 != 5'd0);
            byp_vld2 <= wb_en && (wb_reg == in_rs2) && (in_rs2 != 5'd0);
            byp1     <= wb_data;
            byp2     <= wb_data;
        end else if (fire) begin
            state <= EMPTY;
        end else if (state != EMPTY) begin
            state <= HELD;
            op1_q <= res1;
            op2_q <= res2;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
// ---------------------------------------------------------------------------
// Self-checking bench for operand_fetch. A simple register file surrounds the
// DUT. The reference model treats the stage as a one-entry buffer. Each held
// operand is expected to equal the architectural value of its register, with
// any write landing in the current cycle already included.
// ---------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [4:0]        in_rd;
    logic [4:0]        rf_r_reg1;
    logic [4:0]        rf_r_reg2;
    logic [XLEN-1:0]   rf_r_data1;
    logic [XLEN-1:0]   rf_r_data2;
    logic              wb_en;
    logic [4:0]        wb_reg;
    logic [XLEN-1:0]   wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [CTRL_W-1:0] out_ctrl;
    logic [4:0]        out_rd;
    logic [XLEN-1:0]   out_op1;
    logic [XLEN-1:0]   out_op2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ctrl(in_ctrl),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .rf_r_reg1(rf_r_reg1), .rf_r_reg2(rf_r_reg2),
        .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ctrl(out_ctrl), .out_rd(out_rd),
        .out_op1(out_op1), .out_op2(out_op2)
    );

    // Register file environment: synchronous read with a one-cycle delay.
    // A same-edge write returns the pre-write value, and x0 is never written.
    // Reset clears its contents so it starts from a known state.
    logic [XLEN-1:0] rf_mem [32];
    always @(posedge clk) begin
        rf_r_data1 <= rf_mem[rf_r_reg1];
        rf_r_data2 <= rf_mem[rf_r_reg2];
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (wb_en && (wb_reg != 5'd0)) begin
            rf_mem[wb_reg] <= wb_data;
        end
    end

    // Reference model: architectural registers plus at most one held entry.
    logic [XLEN-1:0]   arch [32];
    logic              m_valid = 1'b0;
    logic [XLEN-1:0]   m_pc;
    logic [CTRL_W-1:0] m_ctrl;
    logic [4:0]        m_rd;
    logic [4:0]        m_rs1;
    logic [4:0]        m_rs2;
    logic              m_acc;
    logic              m_fire;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [XLEN-1:0] archValue(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (wb_en && (wb_reg == r)) return wb_data;
        return arch[r];
    endfunction

    // Samples at the falling edge. It compares the DUT against the model and
    // records whether this cycle accepts and/or fires.
    task automatic applyStimulus();
        logic exp_ready;
        @(negedge clk);
        exp_ready = !rst && !flush && (!m_valid || out_ready);
        checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
        checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
        checkOutput("rf_r_reg1", 64'(rf_r_reg1), 64'(in_rs1));
        checkOutput("rf_r_reg2", 64'(rf_r_reg2), 64'(in_rs2));
        if (m_valid) begin
            checkOutput("out_pc", out_pc, m_pc);
            checkOutput("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
            checkOutput("out_rd", 64'(out_rd), 64'(m_rd));
            checkOutput("out_op1", out_op1, archValue(m_rs1));
            checkOutput("out_op2", out_op2, archValue(m_rs2));
        end
        m_acc  = in_valid && exp_ready;
        m_fire = m_valid && out_ready;
    endtask

    // Updates the model with this cycle's inputs, then moves to just past the
    // next rising edge so the caller can drive new inputs.
    task automatic advance();
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = '0;
            m_ctrl  = '0;
            m_rd    = '0;
            m_rs1   = '0;
            m_rs2   = '0;
            for (int i = 0; i < 32; i++) arch[i] = '0;
        end else begin
            if (wb_en && (wb_reg != 5'd0)) arch[wb_reg] = wb_data;
            if (flush) begin
                m_valid = 1'b0;
            end else if (m_acc) begin
                m_valid = 1'b1;
                m_pc    = in_pc;
                m_ctrl  = in_ctrl;
                m_rd    = in_rd;
                m_rs1   = in_rs1;
                m_rs2   = in_rs2;
            end else if (m_fire) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycleOnce();
        applyStimulus();
        advance();
    endtask

    task automatic idle();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        wb_en     = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;
        out_ready = 1'b1;
    endtask

    task automatic sendInstr(input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2);
        in_valid = 1'b1;
        in_pc    = pc;
        in_ctrl  = pc[31:0] ^ 32'hA5A5_0000;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = pc[6:2];
    endtask

    initial begin
        logic [XLEN-1:0] next_pc;
        logic [XLEN-1:0] fire_pc;
        logic            acc;
        int              fires;

        idle();
        in_pc = '0; in_ctrl = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        rst = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) arch[i] = '0;

        // Reset state, with a pending in_valid that must be refused.
        applyStimulus();
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_pc", out_pc, 64'd0);
        checkOutput("reset_op1", out_op1, 64'd0);
        advance();
        idle();

        // Preload x5 and x6, then a basic fetch.
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 64'h11;
        cycleOnce();
        wb_reg = 5'd6; wb_data = 64'h22;
        cycleOnce();
        idle();
        sendInstr(64'h100, 5'd5, 5'd6);
        cycleOnce();
        idle();
        applyStimulus();
        checkOutput("basic_valid", 64'(out_valid), 64'd1);
        checkOutput("basic_op1", out_op1, 64'h11);
        checkOutput("basic_op2", out_op2, 64'h22);
        advance();

        // Write to rs1 on the accept edge.
        sendInstr(64'h110, 5'd7, 5'd0);
        wb_en = 1'b1; wb_reg = 5'd7; wb_data = 64'hABCD;
        cycleOnce();
        idle();
        applyStimulus();
        checkOutput("bypass_op1", out_op1, 64'hABCD);
        advance();

        // Backpressure for four cycles, with x9 written during the second.
        sendInstr(64'h120, 5'd5, 5'd9);
        out_ready = 1'b0;
        cycleOnce();
        in_valid = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            out_ready = 1'b0;
            wb_en   = (s == 2);
            wb_reg  = 5'd9;
            wb_data = 64'h55;
            applyStimulus();
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_pc", out_pc, 64'h120);
            checkOutput("bp_op1", out_op1, 64'h11);
            if (s >= 2) checkOutput("bp_op2", out_op2, 64'h55);
            advance();
        end
        idle();
        applyStimulus();
        checkOutput("bp_release_op2", out_op2, 64'h55);
        advance();
        applyStimulus();
        checkOutput("bp_empty", 64'(out_valid), 64'd0);
        advance();

        // A write to x0 must never be forwarded.
        sendInstr(64'h130, 5'd0, 5'd5);
        wb_en = 1'b1; wb_reg = 5'd0; wb_data = 64'hFFFF;
        cycleOnce();
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("x0_op1", out_op1, 64'd0);
        checkOutput("x0_op2", out_op2, 64'h11);
        advance();
        idle();

        // Eight instructions back to back.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) sendInstr(64'h200 + 64'(4 * i), 5'(i), 5'(i + 1));
            else in_valid = 1'b0;
            applyStimulus();
            if (i > 0) begin
                checkOutput("b2b_valid", 64'(out_valid), 64'd1);
                checkOutput("b2b_pc", out_pc, 64'h200 + 64'(4 * (i - 1)));
            end
            advance();
        end
        idle();

        // Toggling out_ready: 16 instructions must each leave exactly once, in order.
        next_pc = 64'h300;
        fire_pc = 64'h300;
        fires   = 0;
        for (int c = 0; c < 80 && fires < 16; c++) begin
            if (next_pc < 64'h340) sendInstr(next_pc, 5'(c % 8), 5'((c + 3) % 8));
            else in_valid = 1'b0;
            out_ready = c[0];
            applyStimulus();
            if (m_fire) begin
                checkOutput("toggle_pc", out_pc, fire_pc);
                fire_pc = fire_pc + 64'd4;
                fires++;
            end
            acc = m_acc;
            advance();
            if (acc) next_pc = next_pc + 64'd4;
        end
        checkOutput("toggle_count", 64'(fires), 64'd16);
        idle();

        // Flush while HELD, with a new instruction offered on the same edge.
        sendInstr(64'h400, 5'd6, 5'd5);
        out_ready = 1'b0;
        cycleOnce();
        in_valid = 1'b0;
        cycleOnce();
        flush = 1'b1;
        sendInstr(64'h404, 5'd1, 5'd2);
        applyStimulus();
        checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
        advance();
        idle();
        out_ready = 1'b0;
        applyStimulus();
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        advance();

        // Reset while HELD, with a new instruction offered on the same edge.
        sendInstr(64'h500, 5'd5, 5'd6);
        out_ready = 1'b0;
        cycleOnce();
        in_valid = 1'b0;
        cycleOnce();
        rst = 1'b1;
        sendInstr(64'h504, 5'd1, 5'd2);
        applyStimulus();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        advance();
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_pc", out_pc, 64'd0);
        checkOutput("rst_ctrl", 64'(out_ctrl), 64'd0);
        checkOutput("rst_rd", 64'(out_rd), 64'd0);
        checkOutput("rst_op1", out_op1, 64'd0);
        checkOutput("rst_op2", out_op2, 64'd0);
        advance();
        idle();

        // Randomized traffic over a small register window so hits are frequent.
        for (int c = 0; c < 2500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = {$urandom, $urandom};
            in_ctrl   = $urandom;
            in_rs1    = 5'($urandom_range(0, 7));
            in_rs2    = 5'($urandom_range(0, 7));
            in_rd     = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = ($urandom_range(0, 1) == 1);
            wb_reg    = 5'($urandom_range(0, 7));
            wb_data   = {$urandom, $urandom};
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 255) == 0);
            cycleOnce();
        end
        idle();
        cycleOnce();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
